// File: rtl/mips32_pkg.sv
// Opcode map, instruction-class helpers and FSM encoding for the MIPS32 pipeline sequencer.
// Declarations only: no timing, no flow control.
package mips32_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_AND   = 6'd2;
  localparam logic [OP_W-1:0] OP_OR    = 6'd3;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd4;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd5;
  localparam logic [OP_W-1:0] OP_LW    = 6'd8;
  localparam logic [OP_W-1:0] OP_SW    = 6'd9;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd10;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'd11;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_W-1:0] OP_BNEQZ = 6'd13;
  localparam logic [OP_W-1:0] OP_BEQZ  = 6'd14;
  localparam logic [OP_W-1:0] OP_HLT   = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  function automatic logic is_rr(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
  endfunction

  function automatic logic is_rm(input logic [OP_W-1:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQZ) || (op == OP_BNEQZ);
  endfunction

  function automatic logic writes_reg(input logic [OP_W-1:0] op);
    return is_rr(op) || is_rm(op) || (op == OP_LW);
  endfunction

  // RM and LW carry their destination in rt, so only RR and SW read it.
  function automatic logic uses_rs(input logic [OP_W-1:0] op);
    return is_rr(op) || is_rm(op) || (op == OP_LW) || (op == OP_SW) || is_branch(op);
  endfunction

  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return is_rr(op) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips32_hazard_unit.sv
// Load-use stall and taken-branch flush detection for the MIPS32 sequencer.
// Purely combinational (0 cycles); flush wins over stall, and stall backpressures PC and IF/ID.
module mips32_hazard_unit
  import mips32_pkg::*;
(
  input  logic             i_v_id,
  input  logic             i_v_ex,
  input  logic [OP_W-1:0]  i_id_op,
  input  logic [OP_W-1:0]  i_ex_op,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_a_zero,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_taken
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;

  assign w_rs_hit   = uses_rs(i_id_op) && (i_id_rs == i_ex_rt);
  assign w_rt_hit   = uses_rt(i_id_op) && (i_id_rt == i_ex_rt);
  assign w_load_use = i_v_ex && (i_ex_op == OP_LW) && i_v_id && (w_rs_hit || w_rt_hit);

  assign o_taken = i_v_ex && (((i_ex_op == OP_BEQZ)  &&  i_ex_a_zero) ||
                              ((i_ex_op == OP_BNEQZ) && !i_ex_a_zero));
  assign o_flush = o_taken;
  // A squashed ID instruction cannot need a stall.
  assign o_stall = w_load_use && !o_flush;

endmodule

// File: rtl/mips32_pipe_ctrl.sv
// MIPS32 5-stage sequencer: stage valids, latch enables, stall/flush and HLT drain.
// Strobes are combinational from stage regs; a load-use stall holds PC and IF/ID for one cycle.
module mips32_pipe_ctrl
  import mips32_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_id_opcode,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_ex_a_zero,
  output logic             o_pc_en,
  output logic             o_pc_sel_branch,
  output logic             o_idex_en,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic             o_wb_we,
  output logic             o_halted,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_v_id;
  logic             r_v_ex;
  logic             r_v_mem;
  logic             r_v_wb;
  logic [OP_W-1:0]  r_ex_op;
  logic [OP_W-1:0]  r_mem_op;
  logic [OP_W-1:0]  r_wb_op;
  logic [REG_W-1:0] r_ex_rt;

  logic w_stall;
  logic w_flush;
  logic w_taken;
  logic w_pc_en;
  logic w_idex_en;
  logic w_enter_drain;
  logic w_halted;

  mips32_hazard_unit u_hazard (
    .i_v_id      (r_v_id),
    .i_v_ex      (r_v_ex),
    .i_id_op     (i_id_opcode),
    .i_ex_op     (r_ex_op),
    .i_id_rs     (i_id_rs),
    .i_id_rt     (i_id_rt),
    .i_ex_rt     (r_ex_rt),
    .i_ex_a_zero (i_ex_a_zero),
    .o_stall     (w_stall),
    .o_flush     (w_flush),
    .o_taken     (w_taken)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_en       = 1'b0;
    w_enter_drain = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_pc_en = !w_stall;
        if (r_v_id && (i_id_opcode == OP_HLT) && !w_flush && !w_stall) begin
          w_enter_drain = 1'b1;
          w_state_nxt   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A taken branch ahead of HLT redirects fetch and resumes normal running.
        w_pc_en = w_flush;
        if (w_taken)                              w_state_nxt = ST_RUN;
        else if (r_v_wb && (r_wb_op == OP_HLT))   w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_idex_en = r_v_id && !w_stall && !w_flush;
  assign w_halted  = (r_state == ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_v_id   <= 1'b0;
      r_v_ex   <= 1'b0;
      r_v_mem  <= 1'b0;
      r_v_wb   <= 1'b0;
      r_ex_op  <= '0;
      r_mem_op <= '0;
      r_wb_op  <= '0;
      r_ex_rt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The slot fetched behind HLT is discarded as HLT moves to EX.
      if (w_enter_drain)  r_v_id <= 1'b0;
      else if (!w_stall)  r_v_id <= w_pc_en && !w_flush;
      r_v_ex <= w_idex_en;
      if (w_idex_en) begin
        r_ex_op <= i_id_opcode;
        r_ex_rt <= i_id_rt;
      end
      r_v_mem  <= r_v_ex;
      r_mem_op <= r_ex_op;
      r_v_wb   <= r_v_mem;
      r_wb_op  <= r_mem_op;
    end
  end

  assign o_pc_en         = w_pc_en;
  assign o_pc_sel_branch = w_taken;
  assign o_idex_en       = w_idex_en;
  assign o_stall         = w_stall;
  assign o_flush         = w_flush;
  assign o_mem_rd        = r_v_mem && (r_mem_op == OP_LW) && !w_halted;
  assign o_mem_wr        = r_v_mem && (r_mem_op == OP_SW) && !w_halted;
  assign o_wb_we         = r_v_wb && writes_reg(r_wb_op) && !w_halted;
  assign o_halted        = w_halted;
  assign o_busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  ap_stall_one_cycle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_stall |=> !w_stall);
  ap_flush_over_stall : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_stall && w_flush));
  ap_halted_quiet : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_halted |-> !(o_mem_rd || o_mem_wr || o_wb_we || o_pc_en));

endmodule

// File: tb/tb_mips32_pipe_ctrl.sv
// Directed, table-driven bench for mips32_pipe_ctrl: each row is one cycle of IF/ID contents
// and the hand-computed output vector {pc_en,sel,idex,stall,flush,rd,wr,we,halted,busy}.
module tb_mips32_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] id_opcode = 6'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       ex_a_zero = 1'b0;
  logic pc_en, pc_sel_branch, idex_en, stall, flush, mem_rd, mem_wr, wb_we, halted, busy;

  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, LW = 6'd8, SW = 6'd9, ADDI = 6'd10;
  localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63, NOP = 6'd20;

  localparam logic [9:0] PE = 10'b1000000000, SEL = 10'b0100000000, IX = 10'b0010000000;
  localparam logic [9:0] ST = 10'b0001000000, FL = 10'b0000100000, RD = 10'b0000010000;
  localparam logic [9:0] WR = 10'b0000001000, WE = 10'b0000000100, HA = 10'b0000000010;
  localparam logic [9:0] BU = 10'b0000000001, Z = 10'b0000000000;

  typedef struct {
    logic       start;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       az;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  mips32_pipe_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_id_opcode     (id_opcode),
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .i_ex_a_zero     (ex_a_zero),
    .o_pc_en         (pc_en),
    .o_pc_sel_branch (pc_sel_branch),
    .o_idex_en       (idex_en),
    .o_stall         (stall),
    .o_flush         (flush),
    .o_mem_rd        (mem_rd),
    .o_mem_wr        (mem_wr),
    .o_wb_we         (wb_we),
    .o_halted        (halted),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] outs();
    return {pc_en, pc_sel_branch, idex_en, stall, flush, mem_rd, mem_wr, wb_we, halted, busy};
  endfunction

  task automatic check(input string name, input int cyc, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got=%b want=%b (pe sel ix st fl rd wr we ha bu)", name, cyc, got, exp);
    end
  endtask

  task automatic row(input logic s, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic az, input logic [9:0] exp);
    vec_t v;
    v.start = s; v.op = op; v.rs = rs; v.rt = rt; v.az = az; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      @(negedge clk);
      start     = tbl[i].start;
      id_opcode = tbl[i].op;
      id_rs     = tbl[i].rs;
      id_rt     = tbl[i].rt;
      ex_a_zero = tbl[i].az;
      #1;
      check(name, i, outs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; id_opcode = NOP; id_rs = 5'd0; id_rt = 5'd0; ex_a_zero = 1'b0;
    #1;
    check("reset_outputs", 0, outs(), Z);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Independent ADD, ADDI, SW, LW: first fetch cycle 1, WB at 5/6/8, SW in MEM at 6, LW at 7.
    do_reset();
    row(1, NOP,  0, 0, 0, Z);
    row(0, NOP,  0, 0, 0, PE|BU);
    row(0, ADD,  2, 3, 0, PE|IX|BU);
    row(0, ADDI, 5, 4, 0, PE|IX|BU);
    row(0, SW,   6, 7, 0, PE|IX|BU);
    row(0, LW,   8, 9, 0, PE|IX|WE|BU);
    row(0, NOP,  0, 0, 0, PE|IX|WR|WE|BU);
    row(0, NOP,  0, 0, 0, PE|IX|RD|BU);
    row(0, NOP,  0, 0, 0, PE|IX|WE|BU);
    run_tbl("independent");

    // LW r2 then ADD reading r2 via rs: one stall cycle, ADD retires a cycle late.
    do_reset();
    row(1, NOP, 0, 0, 0, Z);
    row(0, NOP, 0, 0, 0, PE|BU);
    row(0, LW,  1, 2, 0, PE|IX|BU);
    row(0, ADD, 2, 4, 0, ST|BU);
    row(0, ADD, 2, 4, 0, PE|IX|RD|BU);
    row(0, NOP, 0, 0, 0, PE|IX|WE|BU);
    row(0, NOP, 0, 0, 0, PE|IX|BU);
    row(0, NOP, 0, 0, 0, PE|IX|WE|BU);
    run_tbl("load_use_rs");

    // rt match on ADDI must not stall; rt match on SW must.
    do_reset();
    row(1, NOP,  0, 0, 0, Z);
    row(0, NOP,  0, 0, 0, PE|BU);
    row(0, LW,   1, 2, 0, PE|IX|BU);
    row(0, ADDI, 3, 2, 0, PE|IX|BU);
    row(0, LW,   1, 6, 0, PE|IX|RD|BU);
    row(0, SW,   1, 6, 0, ST|WE|BU);
    row(0, SW,   1, 6, 0, PE|IX|RD|WE|BU);
    row(0, NOP,  0, 0, 0, PE|IX|WE|BU);
    row(0, NOP,  0, 0, 0, PE|IX|WR|BU);
    run_tbl("load_use_rt");

    // BEQZ taken: one flush cycle, two wrong-path slots never write back.
    do_reset();
    row(1, NOP,  0, 0, 1, Z);
    row(0, NOP,  0, 0, 1, PE|BU);
    row(0, BEQZ, 3, 0, 1, PE|IX|BU);
    row(0, ADD,  1, 2, 1, PE|SEL|FL|BU);
    row(0, ADDI, 1, 2, 1, PE|BU);
    row(0, SUB,  1, 2, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|WE|BU);
    run_tbl("beqz_taken");

    // BEQZ not taken: no flush, following ADD retires normally.
    do_reset();
    row(1, NOP,  0, 0, 0, Z);
    row(0, NOP,  0, 0, 0, PE|BU);
    row(0, BEQZ, 3, 0, 0, PE|IX|BU);
    row(0, ADD,  1, 2, 0, PE|IX|BU);
    row(0, NOP,  0, 0, 0, PE|IX|BU);
    row(0, NOP,  0, 0, 0, PE|IX|BU);
    row(0, NOP,  0, 0, 0, PE|IX|WE|BU);
    run_tbl("beqz_not_taken");

    // LW r5 then BNEQZ r5 taken: stall, then flush when the branch reaches EX.
    do_reset();
    row(1, NOP,   0, 0, 0, Z);
    row(0, NOP,   0, 0, 0, PE|BU);
    row(0, LW,    1, 5, 0, PE|IX|BU);
    row(0, BNEQZ, 5, 0, 0, ST|BU);
    row(0, BNEQZ, 5, 0, 0, PE|IX|RD|BU);
    row(0, ADD,   1, 2, 0, PE|SEL|FL|WE|BU);
    row(0, ADDI,  1, 2, 0, PE|BU);
    row(0, SUB,   1, 2, 0, PE|IX|BU);
    row(0, NOP,   0, 0, 0, PE|IX|BU);
    run_tbl("lw_then_bneqz");

    // HLT right behind a taken BEQZ is squashed; machine keeps running.
    do_reset();
    row(1, NOP,  0, 0, 1, Z);
    row(0, NOP,  0, 0, 1, PE|BU);
    row(0, BEQZ, 3, 0, 1, PE|IX|BU);
    row(0, HLT,  0, 0, 1, PE|SEL|FL|BU);
    row(0, NOP,  0, 0, 1, PE|BU);
    row(0, ADD,  1, 2, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|BU);
    row(0, NOP,  0, 0, 1, PE|IX|WE|BU);
    run_tbl("hlt_squashed");

    // ADD then HLT: drain, ADD commits, halted once HLT reaches WB; start ignored after.
    do_reset();
    row(1, NOP, 0, 0, 0, Z);
    row(0, NOP, 0, 0, 0, PE|BU);
    row(0, ADD, 1, 2, 0, PE|IX|BU);
    row(0, HLT, 0, 0, 0, PE|IX|BU);
    row(0, NOP, 0, 0, 0, BU);
    row(0, NOP, 0, 0, 0, WE|BU);
    row(0, NOP, 0, 0, 0, BU);
    row(0, NOP, 0, 0, 0, HA);
    row(1, NOP, 0, 0, 0, HA);
    row(0, NOP, 0, 0, 0, HA);
    run_tbl("hlt_drain");

    // Reset mid-drain while ADD is in WB: outputs clear without a clock edge, then IDLE.
    do_reset();
    row(1, NOP, 0, 0, 0, Z);
    row(0, NOP, 0, 0, 0, PE|BU);
    row(0, ADD, 1, 2, 0, PE|IX|BU);
    row(0, HLT, 0, 0, 0, PE|IX|BU);
    row(0, NOP, 0, 0, 0, BU);
    row(0, NOP, 0, 0, 0, WE|BU);
    run_tbl("drain_before_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mid_drain", 0, outs(), Z);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    row(0, NOP, 0, 0, 0, Z);
    row(0, NOP, 0, 0, 0, Z);
    row(1, NOP, 0, 0, 0, Z);
    row(0, NOP, 0, 0, 0, PE|BU);
    run_tbl("idle_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips32_pipe_ctrl.md
Name: mips32_pipe_ctrl

Overview:
Central sequencer for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB).
- Tracks a valid bit and opcode per stage.
- Generates PC/latch enables, load-use stalls, taken-branch flushes, per-stage write strobes and HLT draining.
- Sits beside the opcode decoder: it consumes the ID-stage opcode and register fields, and drives every pipeline-register enable.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register-index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins fetching from IDLE
id_opcode  in  OP_W  opcode in IF/ID latch
id_rs  in  REG_W  rs field in IF/ID latch
id_rt  in  REG_W  rt field in IF/ID latch
ex_a_zero  in  1  EX operand A equals zero (branch condition)
pc_en  out  1  PC and IF/ID latch load enable
pc_sel_branch  out  1  PC loads branch target this cycle
idex_en  out  1  ID/EX latch loads a valid instruction
stall  out  1  load-use stall active
flush  out  1  taken-branch squash active
mem_rd  out  1  data-memory read (LW in MEM)
mem_wr  out  1  data-memory write (SW in MEM)
wb_we  out  1  register-file write (valid writer in WB)
halted  out  1  HLT has retired
busy  out  1  state is RUN or DRAIN

Behaviour:
- Reset, asynchronous, any cycle:
  - state = IDLE.
  - All stage valids = 0; stored opcodes = 0; ex_rt = 0.
  - Every output = 0.
- Opcodes:
  - ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5 (RR).
  - LW=8, SW=9.
  - ADDI=10, SUBI=11, SLTI=12 (RM).
  - BNEQZ=13, BEQZ=14.
  - HLT=63.
  - Any other value: NOP. It passes through the pipe but asserts no strobe.
- FSM, states IDLE, RUN, DRAIN, HALTED:
  - IDLE to RUN on start.
  - RUN to DRAIN when v_id & id_opcode==HLT & ~flush & ~stall.
  - DRAIN back to RUN when a taken branch is in EX. The HLT is squashed.
  - DRAIN to HALTED when v_wb & wb_op==HLT.
  - HALTED is left only by reset. start is ignored outside IDLE.
- pc_en = (state==RUN) & ~stall. It is also 1 in DRAIN when flush (refetch the branch target).
- v_id is registered.
  - Next value = pc_en & ~flush.
  - Holds its value when stall.
  - Cleared when entering DRAIN, after HLT moves to EX.
- Source-register usage:
  - uses_rs: RR, LW, SW, RM, branch.
  - uses_rt: RR, SW.
- Load-use hazard:
  - stall = v_ex & ex_op==LW & v_id & ((uses_rs & id_rs==ex_rt) | (uses_rt & id_rt==ex_rt)).
  - Duration is exactly one cycle, because the LW advances.
  - During stall, a bubble enters EX: v_ex <= 0.
- Taken branch:
  - taken = v_ex & ((ex_op==BEQZ & ex_a_zero) | (ex_op==BNEQZ & ~ex_a_zero)).
  - flush = taken, and pc_sel_branch = taken.
  - The ID instruction and the instruction being fetched are squashed, giving a 2-bubble penalty.
  - The branch itself proceeds to MEM.
- Priority: flush > stall. With both true, stall = 0 and the ID instruction is killed.
- idex_en = v_id & ~stall & ~flush. It is the next value of v_ex.
- Unconditionally: v_mem <= v_ex, v_wb <= v_mem, with opcodes shifting alongside.
- ex_rt captures id_rt when idex_en.
- Registered-stage strobes, combinational from stage registers:
  - mem_rd = v_mem & mem_op==LW.
  - mem_wr = v_mem & mem_op==SW.
  - wb_we = v_wb & (RR | RM | LW).
- halted = (state==HALTED). Once halted, all strobes are 0.
- Latency:
  - An instruction fetched at cycle t sits in ID at t+1, EX t+2, MEM t+3, WB t+4.
  - The first pc_en occurs the cycle after start.

Decomposition:
- Package mips32_pkg: opcode localparams, instruction-class functions (is_rr, is_rm, writes_reg, uses_rs, uses_rt), FSM state encoding.
- Sub-module mips32_hazard_unit: purely combinational. Inputs are v_id, v_ex, opcodes, id_rs/id_rt, ex_rt and ex_a_zero. Outputs are stall, flush and taken.

Test Plan:
- Reset, start, then ADD, ADDI, SW, LW, independent -> pc_en high from cycle 1; wb_we pulses on cycles 5, 6 and 8; mem_wr on cycle 6; mem_rd on cycle 7; no stall.
- LW r2 then ADD r3,r2,r4 -> stall=1 for exactly 1 cycle; pc_en=0 that cycle; ADD's wb_we lands one cycle later than without the hazard.
- BEQZ with ex_a_zero=1 -> flush and pc_sel_branch for 1 cycle; the next 2 fetched instructions never assert wb_we. With ex_a_zero=0 -> no flush.
- LW r5 then BNEQZ r5, taken -> stall 1 cycle, then flush once the branch reaches EX.
- BEQZ taken immediately followed by HLT -> HLT squashed; state stays RUN; halted stays 0.
- ADD then HLT -> pc_en drops after HLT decode; ADD commits; halted=1 when HLT reaches WB. Reset asserted mid-drain -> all outputs 0 asynchronously; state IDLE.
